// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory-handshake stalls and retire counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unknown instructions lock into TRAP.
module multicycle_controller #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    input  logic               br_taken,
    output logic [2:0]         state,
    output logic               mem_req,
    output logic               mem_we,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               retire,
    output logic [CNT_W-1:0]   instr_count,
    output logic               illegal_instr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_BEQ = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_BNE = ALUOP_W'(11);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic is_r, is_j, is_jal, is_jr;
    logic is_beq, is_bne, is_addi, is_andi, is_slti, is_lw, is_sw;
    logic f_add, f_sub, f_and, f_or, f_xor, f_nor, f_slt, f_sll, f_srl;
    logic r_alu, is_imm, legal_exec;
    logic [ALUOP_W-1:0] exec_op;

    assign is_r    = (opcode == 6'b000000);
    assign is_j    = (opcode == 6'b000010);
    assign is_jal  = (opcode == 6'b000011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_bne  = (opcode == 6'b000101);
    assign is_addi = (opcode == 6'b001000);
    assign is_slti = (opcode == 6'b001010);
    assign is_andi = (opcode == 6'b001100);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);

    assign f_add = is_r && (funct == 6'b100000);
    assign f_sub = is_r && (funct == 6'b100010);
    assign f_and = is_r && (funct == 6'b100100);
    assign f_or  = is_r && (funct == 6'b100101);
    assign f_xor = is_r && (funct == 6'b100110);
    assign f_nor = is_r && (funct == 6'b100111);
    assign f_slt = is_r && (funct == 6'b101010);
    assign f_sll = is_r && (funct == 6'b000000);
    assign f_srl = is_r && (funct == 6'b000010);
    assign is_jr = is_r && (funct == 6'b001000);

    assign r_alu  = f_add | f_sub | f_and | f_or | f_xor
                  | f_nor | f_slt | f_sll | f_srl;
    assign is_imm = is_addi | is_andi | is_slti | is_lw | is_sw;
    assign legal_exec = r_alu | is_imm | is_beq | is_bne;

    always_comb begin
        exec_op = '0;
        unique case (1'b1)
            f_add, is_addi, is_lw, is_sw: exec_op = ALU_ADD;
            f_sub:                        exec_op = ALU_SUB;
            f_and, is_andi:               exec_op = ALU_AND;
            f_or:                         exec_op = ALU_OR;
            f_xor:                        exec_op = ALU_XOR;
            f_nor:                        exec_op = ALU_NOR;
            f_slt, is_slti:               exec_op = ALU_SLT;
            f_sll:                        exec_op = ALU_SLL;
            f_srl:                        exec_op = ALU_SRL;
            is_beq:                       exec_op = ALU_BEQ;
            is_bne:                       exec_op = ALU_BNE;
            default:                      exec_op = '0;
        endcase
    end

    // Outputs are decoded from the current state, so reset clears them at once.
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = '0;
        retire        = 1'b0;
        illegal_instr = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                    if (is_jal) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (legal_exec) begin
                    state_d = S_EXEC;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_op  = exec_op;
                alu_src = is_imm;
                if (is_beq || is_bne) begin
                    pc_write = br_taken;
                    pc_src   = 2'd1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r ? 2'd1 : 2'd0;
                mem_to_reg = is_lw;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                illegal_instr = 1'b1;
`endif
                state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + CNT_W'(retire);
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control
// vectors derived from an instruction-level phase model.
module tb_multicycle_controller;

    localparam int CW = 4;

    typedef struct packed {
        logic [2:0]    st;
        logic          mem_req;
        logic          mem_we;
        logic          i_or_d;
        logic          ir_write;
        logic          pc_write;
        logic [1:0]    pc_src;
        logic          reg_write;
        logic [1:0]    reg_dst;
        logic          mem_to_reg;
        logic          alu_src;
        logic [3:0]    alu_op;
        logic          retire;
        logic          ill;
        logic [CW-1:0] cnt;
    } rec_t;

    typedef enum int {
        C_J, C_JAL, C_JR, C_R, C_I, C_LW, C_SW, C_BR, C_ILL
    } cls_e;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, funct;
    logic          mem_ready, br_taken;
    logic [2:0]    state;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic          reg_write;
    logic [1:0]    reg_dst;
    logic          mem_to_reg, alu_src;
    logic [3:0]    alu_op;
    logic          retire;
    logic [CW-1:0] instr_count;
    logic          illegal_instr;

    rec_t          sb[$];
    logic [CW-1:0] cnt_m;
    int            total = 0;
    int            bad = 0;

    multicycle_controller #(.ALUOP_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .br_taken(br_taken), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .retire(retire), .instr_count(instr_count),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rec_t g, e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = {state, mem_req, mem_we, i_or_d, ir_write, pc_write,
                 pc_src, reg_write, reg_dst, mem_to_reg, alu_src,
                 alu_op, retire, illegal_instr, instr_count};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL cycle t=%0t st got=%0d want=%0d vec got=%h want=%h",
                         $time, g.st, e.st, g, e);
            end
        end
    end

    function automatic logic [5:0] r6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cls_e classify(input logic [5:0] op, fn);
        case (op)
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            6'b000100, 6'b000101: return C_BR;
            6'b001000, 6'b001100, 6'b001010: return C_I;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: begin
                if (fn == 6'b001000) return C_JR;
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101010, 6'b000000,
                    6'b000010: return C_R;
                    default: return C_ILL;
                endcase
            end
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [5:0] op, fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: return 4'd1;
                6'b100010: return 4'd2;
                6'b100100: return 4'd3;
                6'b100101: return 4'd4;
                6'b100110: return 4'd5;
                6'b100111: return 4'd6;
                6'b101010: return 4'd7;
                6'b000000: return 4'd8;
                6'b000010: return 4'd9;
                default:   return 4'd0;
            endcase
        end
        case (op)
            6'b001000, 6'b100011, 6'b101011: return 4'd1;
            6'b001100: return 4'd3;
            6'b001010: return 4'd7;
            6'b000100: return 4'd10;
            6'b000101: return 4'd11;
            default:   return 4'd0;
        endcase
    endfunction

    task automatic step(input rec_t e, input logic [5:0] op, fn,
                        input logic mr, br);
        @(posedge clk);
        #1;
        opcode = op;
        funct = fn;
        mem_ready = mr;
        br_taken = br;
        e.cnt = cnt_m;
        sb.push_back(e);
        if (e.retire) cnt_m = cnt_m + 1'b1;
    endtask

    task automatic rst_seq(input bit mid_mem);
        rec_t e;
        e = '0;
        @(posedge clk);
        #1;
        if (mid_mem) begin
            total++;
            if (mem_req !== 1'b1) begin
                bad++;
                $display("FAIL pre_rst_mem_req got=%b want=1", mem_req);
            end
        end
        rst = 1'b0;
        cnt_m = '0;
        sb.push_back(e);
        #1;
        total++;
        if ({mem_req, state, instr_count} !== '0) begin
            bad++;
            $display("FAIL rst_async mem_req=%b st=%0d cnt=%0d want all 0",
                     mem_req, state, instr_count);
        end
        step(e, r6(), r6(), rb(), rb());
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back(e);
    endtask

    task automatic run_instr(input logic [5:0] op, fn, input logic br,
                             input int wf, wm, input bit rst_mem);
        rec_t e;
        cls_e c;
        c = classify(op, fn);
        for (int i = 0; i < wf; i++) begin
            e = '0; e.st = 3'd1; e.mem_req = 1'b1;
            step(e, r6(), r6(), 1'b0, rb());
        end
        e = '0; e.st = 3'd1; e.mem_req = 1'b1;
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(e, r6(), r6(), 1'b1, rb());
        e = '0; e.st = 3'd2;
        case (c)
            C_J:   begin e.pc_write = 1; e.pc_src = 2; e.retire = 1; end
            C_JAL: begin
                e.pc_write = 1; e.pc_src = 2; e.retire = 1;
                e.reg_write = 1; e.reg_dst = 2;
            end
            C_JR:  begin e.pc_write = 1; e.pc_src = 3; e.retire = 1; end
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
            C_ILL: e.retire = 1;
`endif
            default: ;
        endcase
        step(e, op, fn, rb(), rb());
        if (c == C_J || c == C_JAL || c == C_JR) return;
        if (c == C_ILL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++) begin
                e = '0; e.st = 3'd6; e.ill = 1'b1;
                step(e, r6(), r6(), rb(), rb());
            end
            rst_seq(0);
`endif
            return;
        end
        e = '0; e.st = 3'd3;
        e.alu_op = alu_code(op, fn);
        e.alu_src = (c == C_I || c == C_LW || c == C_SW);
        if (c == C_BR) begin
            e.pc_write = br; e.pc_src = 1; e.retire = 1;
        end
        step(e, op, fn, rb(), br);
        if (c == C_BR) return;
        if (c == C_LW || c == C_SW) begin
            for (int i = 0; i < wm; i++) begin
                if (rst_mem && i == 1) begin
                    rst_seq(1);
                    return;
                end
                e = '0; e.st = 3'd4; e.mem_req = 1; e.i_or_d = 1;
                e.mem_we = (c == C_SW);
                step(e, op, fn, 1'b0, rb());
            end
            e = '0; e.st = 3'd4; e.mem_req = 1; e.i_or_d = 1;
            e.mem_we = (c == C_SW); e.retire = (c == C_SW);
            step(e, op, fn, 1'b1, rb());
            if (c == C_SW) return;
        end
        e = '0; e.st = 3'd5; e.reg_write = 1;
        e.reg_dst = (c == C_R) ? 2'd1 : 2'd0;
        e.mem_to_reg = (c == C_LW); e.retire = 1;
        step(e, op, fn, rb(), rb());
    endtask

    task automatic pick(output logic [5:0] op, fn);
        logic [5:0] rf;
        int k;
        k = $urandom_range(0, 19);
        rf = r6();
        fn = rf;
        case (k)
            0: begin op = 6'b000000; fn = 6'b100000; end
            1: begin op = 6'b000000; fn = 6'b100010; end
            2: begin op = 6'b000000; fn = 6'b100100; end
            3: begin op = 6'b000000; fn = 6'b100101; end
            4: begin op = 6'b000000; fn = 6'b100110; end
            5: begin op = 6'b000000; fn = 6'b100111; end
            6: begin op = 6'b000000; fn = 6'b101010; end
            7: begin op = 6'b000000; fn = 6'b000000; end
            8: begin op = 6'b000000; fn = 6'b000010; end
            9: begin op = 6'b000000; fn = 6'b001000; end
            10: op = 6'b000010;
            11: op = 6'b000011;
            12: op = 6'b000100;
            13: op = 6'b000101;
            14: op = 6'b001000;
            15: op = 6'b001100;
            16: op = 6'b001010;
            17: op = 6'b100011;
            18: op = 6'b101011;
            default: begin op = 6'b000000; fn = 6'b001001; end
        endcase
    endtask

    initial begin
        logic [5:0] op, fn;
        rst = 1'b0;
        opcode = '0;
        funct = '0;
        mem_ready = 1'b0;
        br_taken = 1'b0;
        cnt_m = '0;
        rst_seq(0);
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 0);
        run_instr(6'b100011, r6(), 1'b0, 0, 3, 0);
        run_instr(6'b000100, r6(), 1'b1, 0, 0, 0);
        run_instr(6'b000101, r6(), 1'b0, 0, 0, 0);
        run_instr(6'b101011, r6(), 1'b0, 1, 2, 0);
        run_instr(6'b000000, 6'b001000, 1'b0, 2, 0, 0);
        for (int i = 0; i < 20 && cnt_m != {CW{1'b1}}; i++)
            run_instr(6'b000010, r6(), 1'b0, 0, 0, 0);
        run_instr(6'b000011, r6(), 1'b0, 0, 0, 0);
        run_instr(6'b000000, 6'b100111, 1'b0, 0, 0, 0);
        run_instr(6'b111111, r6(), 1'b0, 0, 0, 0);
        run_instr(6'b001100, r6(), 1'b0, 0, 0, 0);
        run_instr(6'b100011, r6(), 1'b0, 0, 3, 1);
        run_instr(6'b001010, r6(), 1'b0, 0, 0, 0);
        repeat (80) begin
            pick(op, fn);
            run_instr(op, fn, rb(), $urandom_range(0, 2),
                      $urandom_range(0, 3), 0);
        end
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
